// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write arbiter.
// Holds the FSM state, grant-source encoding and starvation default.
package rf_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/rf_write_arbiter.sv
// Two-source register-file write arbiter with power-up clear sweep.
// Pipeline writeback (A) has priority; host/debug (B) is forced after starving.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int Dbits      = 32,
  parameter int Nloc       = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [$clog2(Nloc)-1:0] a_addr,
  input  logic [Dbits-1:0]        a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [$clog2(Nloc)-1:0] b_addr,
  input  logic [Dbits-1:0]        b_data,
  output logic                    rf_wr,
  output logic [$clog2(Nloc)-1:0] rf_waddr,
  output logic [Dbits-1:0]        rf_wdata,
  output logic                    grant_src,
  output logic                    init_done
);

  localparam int AW = $clog2(Nloc);
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_q, clr_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [Dbits-1:0] wdata_q, wdata_d;
  src_e            src_q, src_d;
  logic            done_q, done_d;

  logic run;
  logic force_b;
  logic a_hs;
  logic b_hs;

  assign run     = (state_q == RUN);
  assign force_b = b_valid && (starve_q == SW'(STARVE_MAX));
  assign a_ready = run && !force_b;
  assign b_ready = run && (!a_valid || force_b);
  assign a_hs    = a_valid && a_ready;
  assign b_hs    = b_valid && b_ready;

  always_comb begin
    state_d  = state_q;
    clr_d    = clr_q;
    starve_d = starve_q;
    wr_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    src_d    = src_q;
    done_d   = done_q;
    unique case (state_q)
      CLEAR: begin
        clr_d = clr_q + AW'(1);
        if (clr_q == '1) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      RUN: begin
        // Starvation only accrues once arbitration is live.
        if (b_hs || !b_valid) begin
          starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
          starve_d = starve_q + SW'(1);
        end
        unique case (1'b1)
          a_hs: begin
            wr_d    = (a_addr != '0);
            waddr_d = a_addr;
            wdata_d = a_data;
            src_d   = SRC_A;
          end
          b_hs: begin
            wr_d    = (b_addr != '0);
            waddr_d = b_addr;
            wdata_d = b_data;
            src_d   = SRC_B;
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= CLEAR;
      clr_q    <= '0;
      starve_q <= '0;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      src_q    <= SRC_A;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      starve_q <= starve_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      src_q    <= src_d;
      done_q   <= done_d;
    end
  end

  // Clear sweep writes straight from the counter so address 0 lands
  // in the very first cycle after reset release.
  assign rf_wr     = run ? wr_q : !reset;
  assign rf_waddr  = run ? waddr_q : clr_q;
  assign rf_wdata  = run ? wdata_q : '0;
  assign grant_src = src_q;
  assign init_done = done_q;

endmodule
